// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: opcodes, functs, ALU ops,
// sequencer states, trap causes and decoded instruction classes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_SLT  = 2'b11;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        TC_NONE     = 2'b00,
        TC_ILLEGAL  = 2'b01,
        TC_FETCH_TO = 2'b10,
        TC_MISALIGN = 2'b11
    } trap_cause_t;

    typedef enum logic [2:0] {
        IC_ALU  = 3'd0,
        IC_ADDI = 3'd1,
        IC_LW   = 3'd2,
        IC_SW   = 3'd3,
        IC_BEQ  = 3'd4,
        IC_BNE  = 3'd5,
        IC_J    = 3'd6,
        IC_JR   = 3'd7
    } instr_class_t;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/mips_instr_decoder.sv
// Combinational instruction decode: opcode/funct to instruction class and
// datapath control fields, flagging anything outside the supported subset.
module mips_instr_decoder
    import mips_pkg::*;
(
    input  logic [5:0]   i_opcode,
    input  logic [5:0]   i_funct,
    output instr_class_t o_class,
    output logic [1:0]   o_alu_op,
    output logic         o_alu_src,
    output logic         o_reg_dst,
    output logic         o_illegal
);

    always_comb begin
        o_class   = IC_ALU;
        o_alu_op  = ALU_ADD;
        o_alu_src = 1'b0;
        o_reg_dst = 1'b0;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_reg_dst = 1'b1;
                case (i_funct)
                    FN_ADD:  o_alu_op = ALU_ADD;
                    FN_SUB:  o_alu_op = ALU_SUB;
                    FN_AND:  o_alu_op = ALU_AND;
                    FN_SLT:  o_alu_op = ALU_SLT;
                    FN_JR: begin
                        o_class   = IC_JR;
                        o_reg_dst = 1'b0;
                    end
                    default: begin
                        o_reg_dst = 1'b0;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI: begin
                o_class   = IC_ADDI;
                o_alu_src = 1'b1;
            end
            OP_LW: begin
                o_class   = IC_LW;
                o_alu_src = 1'b1;
            end
            OP_SW: begin
                o_class   = IC_SW;
                o_alu_src = 1'b1;
            end
            OP_BEQ: begin
                o_class  = IC_BEQ;
                o_alu_op = ALU_SUB;
            end
            OP_BNE: begin
                o_class  = IC_BNE;
                o_alu_op = ALU_SUB;
            end
            OP_J:    o_class = IC_J;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_sequencer.sv
// Multi-cycle MIPS control sequencer: owns PC and IR, fetches over req/ack and
// steps the datapath one phase per state. All outputs are registered.
//
//   state  | meaning
//   FETCH  | imem_req high, waiting for imem_ack (bounded by FETCH_TIMEOUT)
//   DECODE | pc += 4, reject unsupported encodings
//   EXEC   | ALU controls valid; branches/jumps resolve here
//   MEM    | dmem_req high until dmem_ack
//   WB     | single-cycle register-file write
//   TRAP   | halted, everything idle until reset
module mips_mc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic        o_alu_src,
    output logic [1:0]  o_alu_op,
    input  logic        i_alu_zero,
    input  logic [31:0] i_rs_data,
    output logic        o_reg_write,
    output logic        o_reg_dst,
    output logic        o_wb_sel,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    input  logic        i_dmem_ack,
    output logic        o_retire,
    output logic        o_trap,
    output logic [1:0]  o_trap_cause
);

    localparam int unsigned   TW      = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(FETCH_TIMEOUT - 1);

    seq_state_t   r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_ir;
    logic [TW-1:0] r_wait_cnt;
    logic         r_imem_req;
    logic         r_alu_src;
    logic [1:0]   r_alu_op;
    logic         r_reg_write;
    logic         r_reg_dst;
    logic         r_wb_sel;
    logic         r_dmem_req;
    logic         r_dmem_we;
    logic         r_retire;
    logic         r_trap;
    trap_cause_t  r_trap_cause;

    instr_class_t w_class;
    logic [1:0]   w_alu_op;
    logic         w_alu_src;
    logic         w_reg_dst;
    logic         w_illegal;
    logic [31:0]  w_pc_branch;
    logic [31:0]  w_pc_jump;
    logic         w_taken;

    mips_instr_decoder u_decoder (
        .i_opcode  (r_ir[31:26]),
        .i_funct   (r_ir[5:0]),
        .o_class   (w_class),
        .o_alu_op  (w_alu_op),
        .o_alu_src (w_alu_src),
        .o_reg_dst (w_reg_dst),
        .o_illegal (w_illegal)
    );

    // r_pc already holds pc+4 by the time EXEC uses these targets
    assign w_pc_branch = r_pc + branch_offset(r_ir[15:0]);
    assign w_pc_jump   = {r_pc[31:28], r_ir[25:0], 2'b00};
    assign w_taken     = (w_class == IC_BEQ) ? i_alu_zero : ~i_alu_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_ir         <= 32'h0;
            r_wait_cnt   <= '0;
            r_imem_req   <= 1'b0;
            r_alu_src    <= 1'b0;
            r_alu_op     <= ALU_ADD;
            r_reg_write  <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_wb_sel     <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_retire     <= 1'b0;
            r_trap       <= 1'b0;
            r_trap_cause <= TC_NONE;
        end else begin
            r_retire    <= 1'b0;
            r_reg_write <= 1'b0;
            r_reg_dst   <= 1'b0;
            r_wb_sel    <= 1'b0;
            r_alu_src   <= 1'b0;
            r_alu_op    <= ALU_ADD;
            case (r_state)
                FETCH: begin
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                    end else if (i_imem_ack) begin
                        r_ir       <= i_imem_rdata;
                        r_imem_req <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= DECODE;
                    end else if (r_wait_cnt == TO_LAST) begin
                        r_imem_req   <= 1'b0;
                        r_wait_cnt   <= '0;
                        r_trap       <= 1'b1;
                        r_trap_cause <= TC_FETCH_TO;
                        r_state      <= TRAP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                DECODE: begin
                    r_pc <= r_pc + 32'd4;
                    if (w_illegal) begin
                        r_trap       <= 1'b1;
                        r_trap_cause <= TC_ILLEGAL;
                        r_state      <= TRAP;
                    end else begin
                        r_alu_src <= w_alu_src;
                        r_alu_op  <= w_alu_op;
                        r_state   <= EXEC;
                    end
                end
                EXEC: begin
                    case (w_class)
                        IC_ALU, IC_ADDI: begin
                            r_reg_write <= 1'b1;
                            r_reg_dst   <= w_reg_dst;
                            r_state     <= WB;
                        end
                        IC_LW, IC_SW: begin
                            r_dmem_req <= 1'b1;
                            r_dmem_we  <= (w_class == IC_SW);
                            r_state    <= MEM;
                        end
                        IC_BEQ, IC_BNE: begin
                            if (w_taken) r_pc <= w_pc_branch;
                            r_retire   <= 1'b1;
                            r_imem_req <= 1'b1;
                            r_state    <= FETCH;
                        end
                        IC_J: begin
                            r_pc       <= w_pc_jump;
                            r_retire   <= 1'b1;
                            r_imem_req <= 1'b1;
                            r_state    <= FETCH;
                        end
                        default: begin
                            if (i_rs_data[1:0] != 2'b00) begin
                                r_trap       <= 1'b1;
                                r_trap_cause <= TC_MISALIGN;
                                r_state      <= TRAP;
                            end else begin
                                r_pc       <= i_rs_data;
                                r_retire   <= 1'b1;
                                r_imem_req <= 1'b1;
                                r_state    <= FETCH;
                            end
                        end
                    endcase
                end
                MEM: begin
                    if (i_dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        if (r_dmem_we) begin
                            r_retire   <= 1'b1;
                            r_imem_req <= 1'b1;
                            r_state    <= FETCH;
                        end else begin
                            r_reg_write <= 1'b1;
                            r_wb_sel    <= 1'b1;
                            r_state     <= WB;
                        end
                    end
                end
                WB: begin
                    r_retire   <= 1'b1;
                    r_imem_req <= 1'b1;
                    r_state    <= FETCH;
                end
                TRAP: begin
                    r_state <= TRAP;
                end
                default: begin
                    r_state <= TRAP;
                end
            endcase
        end
    end

    assign o_imem_req   = r_imem_req;
    assign o_imem_addr  = r_pc;
    assign o_instr      = r_ir;
    assign o_alu_src    = r_alu_src;
    assign o_alu_op     = r_alu_op;
    assign o_reg_write  = r_reg_write;
    assign o_reg_dst    = r_reg_dst;
    assign o_wb_sel     = r_wb_sel;
    assign o_dmem_req   = r_dmem_req;
    assign o_dmem_we    = r_dmem_we;
    assign o_retire     = r_retire;
    assign o_trap       = r_trap;
    assign o_trap_cause = r_trap_cause;

endmodule

// File: tb/tb_mips_mc_sequencer.sv
// Directed bench for the multi-cycle MIPS sequencer: a table of single
// instructions with hand-computed outcomes, then trap and reset sequences.
module tb_mips_mc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack = 1'b0;
    logic [31:0] i_imem_rdata = 32'h0;
    logic [31:0] o_instr;
    logic        o_alu_src;
    logic [1:0]  o_alu_op;
    logic        i_alu_zero = 1'b0;
    logic [31:0] i_rs_data = 32'h0;
    logic        o_reg_write;
    logic        o_reg_dst;
    logic        o_wb_sel;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic        i_dmem_ack = 1'b0;
    logic        o_retire;
    logic        o_trap;
    logic [1:0]  o_trap_cause;

    always #5 clk = ~clk;

    mips_mc_sequencer #(
        .RESET_PC      (32'h0000_0000),
        .FETCH_TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_ack   (i_imem_ack),
        .i_imem_rdata (i_imem_rdata),
        .o_instr      (o_instr),
        .o_alu_src    (o_alu_src),
        .o_alu_op     (o_alu_op),
        .i_alu_zero   (i_alu_zero),
        .i_rs_data    (i_rs_data),
        .o_reg_write  (o_reg_write),
        .o_reg_dst    (o_reg_dst),
        .o_wb_sel     (o_wb_sel),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .i_dmem_ack   (i_dmem_ack),
        .o_retire     (o_retire),
        .o_trap       (o_trap),
        .o_trap_cause (o_trap_cause)
    );

    typedef struct {
        logic [31:0] instr;
        logic        alu_zero;
        logic [31:0] rs_data;
        int          dwait;
        int          lat;
        logic [31:0] pc;
        int          rw;
        logic        reg_dst;
        logic        wb_sel;
        logic [1:0]  alu_op;
        logic        alu_src;
        int          dmem;
        logic        we;
    } vec_t;

    typedef struct {
        int          req_n;
        logic [31:0] pc;
        int          rw;
        int          rw_n;
        logic        reg_dst;
        logic        wb_sel;
        logic [1:0]  alu_op;
        logic        alu_src;
        int          dmem;
        logic        we;
        int          retire;
        logic        trap;
        logic [1:0]  cause;
    } obs_t;

    localparam int NV = 16;
    vec_t vt[NV];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic wait_req(input int idx);
        int k;
        k = 0;
        while (!o_imem_req && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("req_wait", idx, 32'(o_imem_req), 32'd1);
    endtask

    // Called at a negedge with imem_req high: acks the fetch and watches the instruction to completion.
    task automatic run_vec(input vec_t v, output obs_t o);
        int dcnt;
        o.req_n = 0; o.pc = 32'h0; o.rw = 0; o.rw_n = 0; o.reg_dst = 1'b0; o.wb_sel = 1'b0;
        o.alu_op = 2'b00; o.alu_src = 1'b0; o.dmem = 0; o.we = 1'b0; o.retire = 0;
        o.trap = 1'b0; o.cause = 2'b00;
        dcnt = 0;
        i_imem_ack   = 1'b1;
        i_imem_rdata = v.instr;
        i_alu_zero   = v.alu_zero;
        i_rs_data    = v.rs_data;
        for (int n = 2; n <= 40; n++) begin
            @(negedge clk);
            i_imem_ack = 1'b0;
            if (n == 3) begin
                o.alu_op  = o_alu_op;
                o.alu_src = o_alu_src;
            end
            if (o_retire) o.retire++;
            if (o_reg_write) begin
                o.rw++;
                o.rw_n    = n;
                o.reg_dst = o_reg_dst;
                o.wb_sel  = o_wb_sel;
            end
            if (o_dmem_req) begin
                o.dmem++;
                if (o_dmem_we) o.we = 1'b1;
                i_dmem_ack = (dcnt == v.dwait);
                dcnt++;
            end else begin
                i_dmem_ack = 1'b0;
            end
            if (o_trap) begin
                o.trap  = 1'b1;
                o.cause = o_trap_cause;
                o.pc    = o_imem_addr;
                break;
            end
            if (o_imem_req) begin
                o.req_n = n;
                o.pc    = o_imem_addr;
                break;
            end
        end
        i_dmem_ack = 1'b0;
    endtask

    task automatic do_reset(input int idx);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_trap", idx, 32'(o_trap), 32'd0);
        check("rst_pc", idx, o_imem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vec_t tv;
        obs_t ob;
        int   cnt;

        //          instr          z     rs_data       dw lat pc             rw rdst  wbsel alu    src   dm we
        vt[0]  = '{32'h00221820, 1'b0, 32'h0,        0, 4, 32'h0000_0004, 1, 1'b1, 1'b0, 2'b00, 1'b0, 0, 1'b0};
        vt[1]  = '{32'h00221822, 1'b0, 32'h0,        0, 4, 32'h0000_0008, 1, 1'b1, 1'b0, 2'b01, 1'b0, 0, 1'b0};
        vt[2]  = '{32'h1022FFFF, 1'b1, 32'h0,        0, 3, 32'h0000_0008, 0, 1'b0, 1'b0, 2'b01, 1'b0, 0, 1'b0};
        vt[3]  = '{32'h1022FFFF, 1'b0, 32'h0,        0, 3, 32'h0000_000C, 0, 1'b0, 1'b0, 2'b01, 1'b0, 0, 1'b0};
        vt[4]  = '{32'h00221824, 1'b0, 32'h0,        0, 4, 32'h0000_0010, 1, 1'b1, 1'b0, 2'b10, 1'b0, 0, 1'b0};
        vt[5]  = '{32'h0022182A, 1'b0, 32'h0,        0, 4, 32'h0000_0014, 1, 1'b1, 1'b0, 2'b11, 1'b0, 0, 1'b0};
        vt[6]  = '{32'h20220005, 1'b0, 32'h0,        0, 4, 32'h0000_0018, 1, 1'b0, 1'b0, 2'b00, 1'b1, 0, 1'b0};
        vt[7]  = '{32'h8C220008, 1'b0, 32'h0,        3, 8, 32'h0000_001C, 1, 1'b0, 1'b1, 2'b00, 1'b1, 4, 1'b0};
        vt[8]  = '{32'hAC220008, 1'b0, 32'h0,        0, 4, 32'h0000_0020, 0, 1'b0, 1'b0, 2'b00, 1'b1, 1, 1'b1};
        vt[9]  = '{32'h14220004, 1'b0, 32'h0,        0, 3, 32'h0000_0034, 0, 1'b0, 1'b0, 2'b01, 1'b0, 0, 1'b0};
        vt[10] = '{32'h14220004, 1'b1, 32'h0,        0, 3, 32'h0000_0038, 0, 1'b0, 1'b0, 2'b01, 1'b0, 0, 1'b0};
        vt[11] = '{32'h08000040, 1'b0, 32'h0,        0, 3, 32'h0000_0100, 0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b0};
        vt[12] = '{32'h00200008, 1'b0, 32'h200,      0, 3, 32'h0000_0200, 0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b0};
        vt[13] = '{32'h10228000, 1'b1, 32'h0,        0, 3, 32'hFFFE_0204, 0, 1'b0, 1'b0, 2'b01, 1'b0, 0, 1'b0};
        vt[14] = '{32'h0BFFFFFF, 1'b0, 32'h0,        0, 3, 32'hFFFF_FFFC, 0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b0};
        vt[15] = '{32'h00221820, 1'b0, 32'h0,        0, 4, 32'h0000_0000, 1, 1'b1, 1'b0, 2'b00, 1'b0, 0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_imem_req", 0, 32'(o_imem_req), 32'd0);
        check("rst_imem_addr", 0, o_imem_addr, 32'h0);
        check("rst_instr", 0, o_instr, 32'h0);
        check("rst_trap", 0, 32'(o_trap), 32'd0);
        check("rst_cause", 0, 32'(o_trap_cause), 32'd0);
        check("rst_strobes", 0, 32'({o_reg_write, o_dmem_req, o_retire}), 32'd0);
        reset = 1'b0;
        #1;
        check("req_before_edge", 0, 32'(o_imem_req), 32'd0);
        @(negedge clk);
        check("req_first_cycle", 0, 32'(o_imem_req), 32'd1);

        for (int i = 0; i < NV; i++) begin
            wait_req(i);
            run_vec(vt[i], ob);
            check("latency", i, 32'(ob.req_n), 32'(vt[i].lat + 1));
            check("next_pc", i, ob.pc, vt[i].pc);
            check("reg_write_cnt", i, 32'(ob.rw), 32'(vt[i].rw));
            if (vt[i].rw != 0) check("reg_write_cycle", i, 32'(ob.rw_n), 32'(vt[i].lat));
            check("reg_dst", i, 32'(ob.reg_dst), 32'(vt[i].reg_dst));
            check("wb_sel", i, 32'(ob.wb_sel), 32'(vt[i].wb_sel));
            check("alu_op", i, 32'(ob.alu_op), 32'(vt[i].alu_op));
            check("alu_src", i, 32'(ob.alu_src), 32'(vt[i].alu_src));
            check("dmem_req_cycles", i, 32'(ob.dmem), 32'(vt[i].dmem));
            check("dmem_we", i, 32'(ob.we), 32'(vt[i].we));
            check("retire_cnt", i, 32'(ob.retire), 32'd1);
            check("no_trap", i, 32'(ob.trap), 32'd0);
        end

        // JR to a misaligned target at pc 0
        wait_req(100);
        tv = vt[12];
        tv.rs_data = 32'h0000_0102;
        run_vec(tv, ob);
        check("jr_trap", 100, 32'(ob.trap), 32'd1);
        check("jr_cause", 100, 32'(ob.cause), 32'd3);
        check("jr_retire", 100, 32'(ob.retire), 32'd0);
        check("jr_pc", 100, ob.pc, 32'h4);
        cnt = 0;
        i_imem_ack = 1'b1;
        i_imem_rdata = 32'h00221820;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_imem_req || o_dmem_req || o_reg_write || o_retire) cnt++;
        end
        i_imem_ack = 1'b0;
        check("trap_idle_cycles", 100, 32'(cnt), 32'd0);
        check("trap_sticky", 100, 32'({o_trap, o_trap_cause}), 32'b111);
        check("trap_pc_frozen", 100, o_imem_addr, 32'h4);
        check("trap_ir_frozen", 100, o_instr, 32'h00200008);
        do_reset(100);

        // Illegal opcode and illegal funct
        wait_req(101);
        tv = vt[0];
        tv.instr = 32'hFC00_0000;
        run_vec(tv, ob);
        check("ill_op_trap", 101, 32'(ob.trap), 32'd1);
        check("ill_op_cause", 101, 32'(ob.cause), 32'd1);
        check("ill_op_pc", 101, ob.pc, 32'h4);
        do_reset(101);
        wait_req(102);
        tv.instr = 32'h0022_1821;
        run_vec(tv, ob);
        check("ill_fn_trap", 102, 32'(ob.trap), 32'd1);
        check("ill_fn_cause", 102, 32'(ob.cause), 32'd1);
        do_reset(102);

        // Fetch never acknowledged
        wait_req(103);
        cnt = 0;
        while (o_imem_req && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_req_cycles", 103, 32'(cnt), 32'd16);
        check("timeout_trap", 103, 32'(o_trap), 32'd1);
        check("timeout_cause", 103, 32'(o_trap_cause), 32'd2);
        do_reset(103);

        // Asynchronous reset in the middle of a load's MEM phase
        wait_req(104);
        i_imem_ack = 1'b1;
        i_imem_rdata = 32'h8C220008;
        cnt = 0;
        @(negedge clk);
        i_imem_ack = 1'b0;
        while (!o_dmem_req && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("mem_reached", 104, 32'(o_dmem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_dmem_req", 104, 32'(o_dmem_req), 32'd0);
        check("async_pc", 104, o_imem_addr, 32'h0);
        check("async_ir", 104, o_instr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        wait_req(105);
        check("restart_addr", 105, o_imem_addr, 32'h0);
        check("restart_trap", 105, 32'({o_trap, o_trap_cause}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
